// File: rtl/prm_pkg.sv
// Shared constants, types and helpers for the PRM edge sweep generator.
package prm_pkg;

    localparam int NJ      = 5;
    localparam int JW      = 3;
    localparam int CODE_W  = NJ * JW;
    localparam int NSTEP   = 8;
    localparam int STEP_W  = $clog2(NSTEP + 1);
    localparam int SHIFT_W = $clog2(NSTEP);
    localparam int PROD_W  = JW + 1 + SHIFT_W + 1;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic signed [JW:0] delta_t;
    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_t;

    function automatic delta_t joint_delta(input logic [JW-1:0] s, input logic [JW-1:0] e);
        return $signed({1'b0, e}) - $signed({1'b0, s});
    endfunction

endpackage

// File: rtl/prm_edge_sweep_gen_if.sv
// Request, checker and response signals of the edge sweep generator.
interface prm_edge_sweep_gen_if;
    import prm_pkg::*;

    logic  req_valid;
    logic  req_ready;
    code_t req_start;
    code_t req_end;
    code_t chk_code;
    logic  chk_valid;
    logic  chk_mask;
    logic  rsp_valid;
    logic  rsp_ready;
    logic  rsp_blocked;
    step_t rsp_hit_step;

    modport slave (
        input  req_valid, req_start, req_end, chk_mask, rsp_ready,
        output req_ready, chk_code, chk_valid, rsp_valid, rsp_blocked, rsp_hit_step
    );

    modport master (
        output req_valid, req_start, req_end, chk_mask, rsp_ready,
        input  req_ready, chk_code, chk_valid, rsp_valid, rsp_blocked, rsp_hit_step
    );

endinterface

// File: rtl/prm_lerp_joint.sv
// One joint of the segment walk: p = start + floor(delta * k / NSTEP).
module prm_lerp_joint
    import prm_pkg::*;
(
    input  logic [JW-1:0] i_start,
    input  delta_t        i_delta,
    input  step_t         i_k,
    output logic [JW-1:0] o_p
);

    logic signed [PROD_W-1:0] w_delta_ext;
    logic signed [PROD_W-1:0] w_k_ext;
    logic signed [PROD_W-1:0] w_start_ext;
    logic signed [PROD_W-1:0] w_prod;

    assign w_delta_ext = {{(PROD_W-JW-1){i_delta[JW]}}, i_delta};
    assign w_k_ext     = {{(PROD_W-STEP_W){1'b0}}, i_k};
    assign w_start_ext = {{(PROD_W-JW){1'b0}}, i_start};
    assign w_prod      = w_delta_ext * w_k_ext;

    // Arithmetic shift floors negative products; the sum always lands back in joint range.
    assign o_p = JW'(w_start_ext + (w_prod >>> SHIFT_W));

endmodule

// File: rtl/prm_edge_sweep_gen.sv
// PRM edge sweep driver: walks start->end in NSTEP+1 points and ORs checker replies.
// Optional macro PRM_SWEEP_EARLY_EXIT_EN ends the sweep at the first blocked point.
module prm_edge_sweep_gen
    import prm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    prm_edge_sweep_gen_if.slave bus
);

    sweep_state_t r_state;
    sweep_state_t w_next_state;
    code_t        r_start;
    code_t        r_code;
    code_t        w_point;
    delta_t       r_delta [NJ];
    step_t        r_k;
    logic         r_blocked;
    step_t        r_hit_step;
    logic         w_accept;
    logic         w_first_hit;
    logic         w_last;

    assign w_accept    = (r_state == IDLE) && bus.req_valid;
    assign w_first_hit = (r_state == SWEEP) && bus.chk_mask && !r_blocked;
    assign w_last      = (r_k == step_t'(NSTEP));

    for (genvar j = 0; j < NJ; j++) begin : g_joint
        prm_lerp_joint u_lerp (
            .i_start (r_start[JW*j +: JW]),
            .i_delta (r_delta[j]),
            .i_k     (r_k),
            .o_p     (w_point[JW*j +: JW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        bus.req_ready    = 1'b0;
        bus.chk_valid    = 1'b0;
        bus.chk_code     = r_code;
        bus.rsp_valid    = 1'b0;
        bus.rsp_blocked  = r_blocked;
        bus.rsp_hit_step = r_hit_step;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = SWEEP;
                end
            end
            SWEEP: begin
                bus.chk_valid = 1'b1;
                bus.chk_code  = w_point;
`ifdef PRM_SWEEP_EARLY_EXIT_EN
                if (w_last || w_first_hit) begin
                    w_next_state = DONE;
                end
`else
                if (w_last) begin
                    w_next_state = DONE;
                end
`endif
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // r_code remembers the last issued point so chk_code is steady outside the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start    <= '0;
            r_code     <= '0;
            r_k        <= '0;
            r_blocked  <= 1'b0;
            r_hit_step <= '0;
            for (int j = 0; j < NJ; j++) begin
                r_delta[j] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_start    <= bus.req_start;
                r_k        <= '0;
                r_blocked  <= 1'b0;
                r_hit_step <= '0;
                for (int j = 0; j < NJ; j++) begin
                    r_delta[j] <= joint_delta(bus.req_start[JW*j +: JW], bus.req_end[JW*j +: JW]);
                end
            end
            if (r_state == SWEEP) begin
                r_code <= w_point;
                r_k    <= step_t'(r_k + 1'b1);
                if (w_first_hit) begin
                    r_blocked  <= 1'b1;
                    r_hit_step <= r_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_sweep_gen.sv
// Scoreboard bench for prm_edge_sweep_gen; honours PRM_SWEEP_EARLY_EXIT_EN when defined.
module tb_prm_edge_sweep_gen;
    import prm_pkg::*;

`ifdef PRM_SWEEP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic  blocked;
        step_t hit;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic maskEn;
    code_t maskCode;
    int tests;
    int errors;
    code_t expCode[$];
    rsp_t expRsp[$];

    code_t seqZero  [9] = '{15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0};
    code_t seqUp    [9] = '{15'h0, 15'h0, 15'h1, 15'h2, 15'h3, 15'h4, 15'h5, 15'h6, 15'h7};
    code_t seqDown  [9] = '{15'h7, 15'h6, 15'h5, 15'h4, 15'h3, 15'h2, 15'h1, 15'h0, 15'h0};
    code_t seqMulti [9] = '{15'h00, 15'h00, 15'h09, 15'h0A, 15'h13, 15'h14, 15'h1D, 15'h1E, 15'h27};

    prm_edge_sweep_gen_if bus ();

    prm_edge_sweep_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Obstacle checker model: a single blocked code, replied in the same cycle.
    assign bus.chk_mask = bus.chk_valid && maskEn && (bus.chk_code == maskCode);

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushCodes(input code_t seq [9], input int n);
        for (int i = 0; i < n; i++) begin
            expCode.push_back(seq[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.chk_valid) begin
                tests++;
                if (expCode.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL chk_unexpected: got code %h, expected no point", bus.chk_code);
                end else begin
                    code_t e;
                    e = expCode.pop_front();
                    if (bus.chk_code !== e) begin
                        errors++;
                        $display("[TB] FAIL chk_code: got %h, expected %h at %0t", bus.chk_code, e, $time);
                    end
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                tests++;
                if (expRsp.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got blocked=%b hit=%0d, expected no response",
                             bus.rsp_blocked, bus.rsp_hit_step);
                end else begin
                    rsp_t r;
                    r = expRsp.pop_front();
                    if (bus.rsp_blocked !== r.blocked || bus.rsp_hit_step !== r.hit) begin
                        errors++;
                        $display("[TB] FAIL rsp: got blocked=%b hit=%0d, expected blocked=%b hit=%0d",
                                 bus.rsp_blocked, bus.rsp_hit_step, r.blocked, r.hit);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input code_t s, input code_t e, input logic mEn, input code_t mCode,
                                 input logic expB, input step_t expH, input int expLat, input int hold,
                                 input logic pending, input logic chain, input code_t ns, input code_t ne);
        int lat;
        int guard;
        maskEn   = mEn;
        maskCode = mCode;
        expRsp.push_back('{blocked: expB, hit: expH});
        if (pending) begin
            checkOutput("req_ready_after_handshake", bus.req_ready, 1);
        end else begin
            guard = 0;
            while (!bus.req_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            checkOutput("idle_wait", bus.req_ready, 1);
            bus.req_valid = 1'b1;
            bus.req_start = s;
            bus.req_end   = e;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, expLat);
        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_blocked", bus.rsp_blocked, expB);
            checkOutput("hold_hit_step", bus.rsp_hit_step, expH);
            checkOutput("hold_req_ready", bus.req_ready, 0);
            checkOutput("hold_rsp_valid", bus.rsp_valid, 1);
            if (chain) begin
                bus.req_valid = 1'b1;
                bus.req_start = ns;
                bus.req_end   = ne;
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int rspSeen;
        tests         = 0;
        errors        = 0;
        rst_n         = 1'b0;
        maskEn        = 1'b0;
        maskCode      = '0;
        bus.req_valid = 1'b0;
        bus.req_start = '0;
        bus.req_end   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", bus.req_ready, 1);
        checkOutput("reset_chk_valid", bus.chk_valid, 0);
        checkOutput("reset_chk_code", bus.chk_code, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_rsp_blocked", bus.rsp_blocked, 0);
        checkOutput("reset_rsp_hit_step", bus.rsp_hit_step, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pushCodes(seqZero, 9);
        applyStimulus(15'h0, 15'h0, 1'b0, 15'h0, 1'b0, 4'd0, 10, 0, 1'b0, 1'b0, 15'h0, 15'h0);

        pushCodes(seqUp, 9);
        applyStimulus(15'h0, 15'h7, 1'b0, 15'h0, 1'b0, 4'd0, 10, 0, 1'b0, 1'b0, 15'h0, 15'h0);

        pushCodes(seqUp, EARLY ? 6 : 9);
        applyStimulus(15'h0, 15'h7, 1'b1, 15'h4, 1'b1, 4'd5, EARLY ? 7 : 10, 0, 1'b0, 1'b0, 15'h0, 15'h0);

        pushCodes(seqDown, 9);
        applyStimulus(15'h7, 15'h0, 1'b0, 15'h0, 1'b0, 4'd0, 10, 0, 1'b0, 1'b0, 15'h0, 15'h0);

        pushCodes(seqMulti, EARLY ? 5 : 9);
        applyStimulus(15'h0, 15'h27, 1'b1, 15'h13, 1'b1, 4'd4, EARLY ? 6 : 10, 5, 1'b0, 1'b1, 15'h7, 15'h0);
        pushCodes(seqDown, 9);
        applyStimulus(15'h7, 15'h0, 1'b0, 15'h0, 1'b0, 4'd0, 10, 0, 1'b1, 1'b0, 15'h0, 15'h0);

        // Reset lands in the cycle that would present point k=3.
        pushCodes(seqUp, 3);
        maskEn        = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_start = 15'h0;
        bus.req_end   = 15'h7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_chk_valid", bus.chk_valid, 0);
        checkOutput("midreset_chk_code", bus.chk_code, 0);
        checkOutput("midreset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("midreset_req_ready", bus.req_ready, 1);
        checkOutput("midreset_rsp_blocked", bus.rsp_blocked, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rspSeen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.chk_valid) rspSeen++;
        end
        checkOutput("no_activity_after_reset", rspSeen, 0);

        pushCodes(seqUp, 9);
        applyStimulus(15'h0, 15'h7, 1'b0, 15'h0, 1'b0, 4'd0, 10, 0, 1'b0, 1'b0, 15'h0, 15'h0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("codes_left", expCode.size(), 0);
        checkOutput("rsp_left", expRsp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
